// File: rtl/sha1_padder_pkg.sv
// Shared constants and types for the SHA-1 message padder.
//   SHA1_BLOCK_WORDS : 32-bit words per 512-bit block
//   SHA1_PAD_WORD    : word holding only the leading 0x80 pad byte
//   CMD_*            : sha1 core cmd_i encodings {Round,W,R}
//   READ_CAP_OFS     : cycle after the read command where H0 appears on text_o
//   state_e          : padder FSM states
package sha1_padder_pkg;

  localparam int          SHA1_BLOCK_WORDS = 16;
  localparam logic [31:0] SHA1_PAD_WORD    = 32'h8000_0000;

  localparam logic [2:0]  CMD_FIRST = 3'b010;
  localparam logic [2:0]  CMD_NEXT  = 3'b110;
  localparam logic [2:0]  CMD_READ  = 3'b001;

  localparam logic [2:0]  READ_CAP_OFS = 3'd3;
  localparam logic [2:0]  READ_LAST    = READ_CAP_OFS + 3'd4;

  typedef enum logic [2:0] {
    ST_FILL      = 3'd0,
    ST_PAD       = 3'd1,
    ST_SEND_CMD  = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_HI   = 3'd4,
    ST_WAIT_LO   = 3'd5,
    ST_READ_CMD  = 3'd6,
    ST_READ      = 3'd7
  } state_e;

endpackage

// File: rtl/sha1_pad_word.sv
// Last-word formatter: keeps the valid upper bytes, zeroes the rest and
// drops the 0x80 pad byte into the first invalid byte.
//   data_i   : raw last word, byte 0 in [31:24]
//   bytes_i  : valid bytes (0 = all four)
//   empty_i  : zero-length message, data_i ignored
//   word_o   : formatted word
//   full_o   : word had no free byte; the pad byte belongs in the next word
//   nbits_o  : message bits carried by this word
module sha1_pad_word
  import sha1_padder_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  bytes_i,
  input  logic        empty_i,
  output logic [31:0] word_o,
  output logic        full_o,
  output logic [5:0]  nbits_o
);

  always_comb begin
    word_o  = data_i;
    full_o  = 1'b0;
    nbits_o = 6'd32;
    if (empty_i) begin
      word_o  = SHA1_PAD_WORD;
      nbits_o = 6'd0;
    end else begin
      case (bytes_i)
        2'd0: full_o = 1'b1;
        2'd1: begin
          word_o  = {data_i[31:24], 8'h80, 16'h0000};
          nbits_o = 6'd8;
        end
        2'd2: begin
          word_o  = {data_i[31:16], 8'h80, 8'h00};
          nbits_o = 6'd16;
        end
        default: begin
          word_o  = {data_i[31:8], 8'h80};
          nbits_o = 6'd24;
        end
      endcase
    end
  end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 padder / sequencer in front of the sha1 core. Buffers one block of a
// big-endian word stream, appends 0x80 / zeros / 64-bit length, feeds the core
// block by block and reads back the digest.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_*                    : message stream (valid/ready, last, bytes, empty)
//   core_text_o/cmd_o/cmd_w_o : drive sha1 text_i / cmd_i / cmd_w_i
//   core_cmd_i, core_text_i : sha1 cmd_o (bit3 busy) and text_o
//   digest_o, digest_valid_o: {H0..H4} and its one-cycle update strobe
//
// state        | meaning
// FILL         | accepting words into the block buffer
// PAD          | building the trailing pad-only block
// SEND_CMD     | write cmd (first/next block)
// SEND_DATA    | stream 16 buffered words to the core
// WAIT_HI      | wait for core busy to rise
// WAIT_LO      | wait for core busy to fall (block done)
// READ_CMD     | write read cmd (cycle c0)
// READ         | capture H0..H4 in c3..c7
module sha1_padder
  import sha1_padder_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  in_data_i,
  input  logic         in_valid_i,
  input  logic         in_last_i,
  input  logic [1:0]   in_bytes_i,
  input  logic         in_empty_i,
  output logic         in_ready_o,
  output logic [31:0]  core_text_o,
  output logic [2:0]   core_cmd_o,
  output logic         core_cmd_w_o,
  input  logic [3:0]   core_cmd_i,
  input  logic [31:0]  core_text_i,
  output logic [159:0] digest_o,
  output logic         digest_valid_o
);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d, len_sum;
  logic               not_first_q, not_first_d;
  logic               final_q, final_d;
  logic               pad_pend_q, pad_pend_d;
  logic               pad_lead_q, pad_lead_d;
  logic [3:0]         word_cnt_q, word_cnt_d;
  logic [2:0]         rd_cnt_q, rd_cnt_d;
  logic [31:0]        blk_q [SHA1_BLOCK_WORDS];
  logic [31:0]        blk_d [SHA1_BLOCK_WORDS];
  logic [31:0]        h_q [4];
  logic [31:0]        h_d [4];
  logic [159:0]       digest_q, digest_d;
  logic               digest_valid_q, digest_valid_d;

  logic [31:0]        pw_word;
  logic               pw_full;
  logic [5:0]         pw_nbits;
  logic [4:0]         pad_pos;
  logic [63:0]        len64_sum, len64_q;
  logic [1:0]         h_sel;
  logic               unused_cmd;

  assign unused_cmd = ^core_cmd_i[2:0];

  sha1_pad_word u_pad_word (
    .data_i  (in_data_i),
    .bytes_i (in_bytes_i),
    .empty_i (in_empty_i),
    .word_o  (pw_word),
    .full_o  (pw_full),
    .nbits_o (pw_nbits)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    not_first_d    = not_first_q;
    final_d        = final_q;
    pad_pend_d     = pad_pend_q;
    pad_lead_d     = pad_lead_q;
    word_cnt_d     = word_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    blk_d          = blk_q;
    h_d            = h_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    in_ready_o     = 1'b0;
    core_cmd_w_o   = 1'b0;
    core_cmd_o     = 3'b000;
    core_text_o    = 32'h0;

    len_sum   = len_q + LEN_W'(pw_nbits);
    len64_sum = 64'(len_sum);
    len64_q   = 64'(len_q);
    // word index holding the 0x80 byte; 16 means it spills into a pad block
    pad_pos   = {1'b0, idx_q} + {4'b0000, pw_full};
    h_sel     = 2'(rd_cnt_q - READ_CAP_OFS);

    case (state_q)
      ST_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (!in_last_i) begin
            blk_d[idx_q] = in_data_i;
            idx_d        = idx_q + 4'd1;  // wraps to 0 for the next block
            len_d        = len_q + LEN_W'(32);
            if (idx_q == 4'd15) begin
              final_d    = 1'b0;
              pad_pend_d = 1'b0;
              state_d    = ST_SEND_CMD;
            end
          end else begin
            len_d = len_sum;
            for (int i = 0; i < SHA1_BLOCK_WORDS; i++) begin
              if (i == int'(idx_q))
                blk_d[i] = pw_word;
              else if (pw_full && (i == int'(idx_q) + 1))
                blk_d[i] = SHA1_PAD_WORD;
              else if (i > int'(pad_pos))
                blk_d[i] = 32'h0;
            end
            if (pad_pos <= 5'd13) begin
              blk_d[14]  = len64_sum[63:32];
              blk_d[15]  = len64_sum[31:0];
              final_d    = 1'b1;
              pad_pend_d = 1'b0;
            end else begin
              final_d    = 1'b0;
              pad_pend_d = 1'b1;
              pad_lead_d = (pad_pos == 5'd16);
            end
            state_d = ST_SEND_CMD;
          end
        end
      end

      ST_PAD: begin
        for (int i = 0; i < SHA1_BLOCK_WORDS; i++) blk_d[i] = 32'h0;
        blk_d[0]   = pad_lead_q ? SHA1_PAD_WORD : 32'h0;
        blk_d[14]  = len64_q[63:32];
        blk_d[15]  = len64_q[31:0];
        final_d    = 1'b1;
        pad_pend_d = 1'b0;
        state_d    = ST_SEND_CMD;
      end

      ST_SEND_CMD: begin
        core_cmd_w_o = 1'b1;
        core_cmd_o   = not_first_q ? CMD_NEXT : CMD_FIRST;
        word_cnt_d   = 4'd0;
        state_d      = ST_SEND_DATA;
      end

      ST_SEND_DATA: begin
        core_text_o = blk_q[word_cnt_q];
        word_cnt_d  = word_cnt_q + 4'd1;
        if (word_cnt_q == 4'd15) state_d = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (core_cmd_i[3]) state_d = ST_WAIT_LO;
      end

      ST_WAIT_LO: begin
        if (!core_cmd_i[3]) begin
          not_first_d = 1'b1;
          if (final_q)         state_d = ST_READ_CMD;
          else if (pad_pend_q) state_d = ST_PAD;
          else                 state_d = ST_FILL;
        end
      end

      ST_READ_CMD: begin
        core_cmd_w_o = 1'b1;
        core_cmd_o   = CMD_READ;
        rd_cnt_d     = 3'd1;
        state_d      = ST_READ;
      end

      ST_READ: begin
        rd_cnt_d = rd_cnt_q + 3'd1;
        if (rd_cnt_q >= READ_CAP_OFS && rd_cnt_q != READ_LAST) h_d[h_sel] = core_text_i;
        if (rd_cnt_q == READ_LAST) begin
          digest_d       = {h_q[0], h_q[1], h_q[2], h_q[3], core_text_i};
          digest_valid_d = 1'b1;
          len_d          = '0;
          idx_d          = 4'd0;
          not_first_d    = 1'b0;
          final_d        = 1'b0;
          pad_pend_d     = 1'b0;
          rd_cnt_d       = 3'd0;
          state_d        = ST_FILL;
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_FILL;
      idx_q          <= 4'd0;
      len_q          <= '0;
      not_first_q    <= 1'b0;
      final_q        <= 1'b0;
      pad_pend_q     <= 1'b0;
      pad_lead_q     <= 1'b0;
      word_cnt_q     <= 4'd0;
      rd_cnt_q       <= 3'd0;
      h_q            <= '{default: '0};
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      not_first_q    <= not_first_d;
      final_q        <= final_d;
      pad_pend_q     <= pad_pend_d;
      pad_lead_q     <= pad_lead_d;
      word_cnt_q     <= word_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
    blk_q <= blk_d;
  end

  assign digest_o       = digest_q;
  assign digest_valid_o = digest_valid_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder with a behavioural sha1 core attached. Known-answer
// and golden-model digests are scoreboarded; command order, core word stream,
// in_ready_o gating and mid-block reset are checked too.
module tb_sha1_padder;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
  logic [1:0]   in_bytes = '0;
  logic         in_ready_o;
  logic [31:0]  core_text_o, core_text_i;
  logic [2:0]   core_cmd_o;
  logic         core_cmd_w_o;
  logic [3:0]   core_cmd_i;
  logic [159:0] digest_o;
  logic         digest_valid_o;

  always #5 clk = ~clk;

  sha1_padder #(.LEN_W(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_bytes_i(in_bytes), .in_empty_i(in_empty), .in_ready_o(in_ready_o),
    .core_text_o(core_text_o), .core_cmd_o(core_cmd_o), .core_cmd_w_o(core_cmd_w_o),
    .core_cmd_i(core_cmd_i), .core_text_i(core_text_i),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o)
  );

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // ---------------- behavioural sha1 core ----------------
  logic         core_busy = 1'b0;
  logic         core_round = 1'b0;
  logic [159:0] core_h = '0;
  logic [511:0] core_blk = '0;
  int           ld_cnt = 0, rnd_cnt = 0, rd_cnt = 0;
  logic [511:0] blk_log [$];
  logic [2:0]   cmd_log [$];
  int           viol = 0, n_dv = 0;

  assign core_cmd_i  = {core_busy, 3'b000};
  assign core_text_i = (rd_cnt >= 3 && rd_cnt <= 7) ? core_h[159-32*(rd_cnt-3) -: 32] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      core_busy <= 1'b0; ld_cnt <= 0; rnd_cnt <= 0; rd_cnt <= 0; core_h <= '0;
    end else begin
      if (core_cmd_w_o && core_cmd_o[1]) begin
        ld_cnt <= 16; core_round <= core_cmd_o[2]; core_busy <= 1'b1;
      end else if (ld_cnt != 0) begin
        core_blk <= {core_blk[479:0], core_text_o};
        ld_cnt   <= ld_cnt - 1;
        if (ld_cnt == 1) begin
          rnd_cnt <= 80;
          blk_log.push_back({core_blk[479:0], core_text_o});
        end
      end else if (rnd_cnt != 0) begin
        rnd_cnt <= rnd_cnt - 1;
        if (rnd_cnt == 1) begin
          core_h    <= sha1_compress(core_round ? core_h : IV, core_blk);
          core_busy <= 1'b0;
        end
      end
      if (core_cmd_w_o && core_cmd_o == 3'b001) rd_cnt <= 1;
      else if (rd_cnt != 0) rd_cnt <= (rd_cnt == 7) ? 0 : rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (core_cmd_w_o) cmd_log.push_back(core_cmd_o);
      if ((in_ready_o && (core_busy || ld_cnt != 0 || rd_cnt != 0 || core_cmd_w_o)) ||
          (ld_cnt == 0 && core_text_o != 32'h0))
        viol <= viol + 1;
      if (digest_valid_o) n_dv <= n_dv + 1;
    end
  end

  // ---------------- stimulus / scoreboard ----------------
  typedef struct {
    int           kind;   // 0 abc, 1 empty, 2 abcdbcde..., 3 zeros, 4 random
    int           n;
    bit           use_c;
    logic [159:0] cexp;
    int           gap;
  } vec_t;

  vec_t         vecs [14];
  logic [7:0]   msg_mem [192];
  logic [159:0] exp_q [$];
  int           n_vec = 0, n_miss = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic fill_msg(input int kind, input int n);
    for (int i = 0; i < 192; i++) msg_mem[i] = 8'h00;
    case (kind)
      0: begin msg_mem[0] = 8'h61; msg_mem[1] = 8'h62; msg_mem[2] = 8'h63; end
      2: for (int g = 0; g < 14; g++)
           for (int j = 0; j < 4; j++) msg_mem[4*g+j] = 8'(8'h61 + g + j);
      4: for (int i = 0; i < n; i++) msg_mem[i] = 8'($urandom_range(0, 255));
      default: ;
    endcase
  endtask

  function automatic logic [159:0] sha1_golden(input int n);
    int           nb, j;
    logic [63:0]  bl;
    logic [7:0]   by;
    logic [159:0] h;
    logic [511:0] blk;
    nb = (n + 8) / 64 + 1;
    bl = 64'(n) * 64'd8;
    h  = IV;
    for (int bi = 0; bi < nb; bi++) begin
      for (int i = 0; i < 64; i++) begin
        j = bi * 64 + i;
        if (j < n)                by = msg_mem[j];
        else if (j == n)          by = 8'h80;
        else if (j >= nb*64 - 8)  by = bl[8*(nb*64-1-j) +: 8];
        else                      by = 8'h00;
        blk[511-8*i -: 8] = by;
      end
      h = sha1_compress(h, blk);
    end
    return h;
  endfunction

  task automatic send_msg(input int n, input int gap);
    int nw, g, b;
    logic [7:0] bytes4 [4];
    nw = (n == 0) ? 1 : (n + 3) / 4;
    @(posedge clk); #1;
    for (int k = 0; k < nw; k++) begin
      g = 0;
      while (gap > 0 && g < 5 && $urandom_range(0, 99) < gap) begin
        in_valid = 1'b0; g++;
        @(posedge clk); #1;
      end
      for (int bb = 0; bb < 4; bb++) begin
        b = 4*k + bb;
        bytes4[bb] = (b < n) ? msg_mem[b] : 8'($urandom_range(0, 255));
      end
      in_data  = {bytes4[0], bytes4[1], bytes4[2], bytes4[3]};
      in_last  = (k == nw - 1);
      in_bytes = 2'(n % 4);
      in_empty = (n == 0);
      in_valid = 1'b1;
      g = 0;
      while (!in_ready_o && g < 2000) begin @(posedge clk); #1; g++; end
      if (g >= 2000) begin
        chk("ready_timeout", 512'(in_ready_o), 512'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    end
  endtask

  task automatic wait_digest(input string nm);
    logic [159:0] e;
    bit got;
    got = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      if (digest_valid_o) got = 1'b1;
    end
    e = exp_q.pop_front();
    if (!got) chk({nm, "_digest_timeout"}, 512'(digest_valid_o), 512'd1);
    else      chk({nm, "_digest"}, 512'(digest_o), 512'(e));
  endtask

  task automatic run_msg(input string nm, input int n, input bit use_c,
                         input logic [159:0] cexp, input int gap);
    int c0, v0, d0, nb, nc, bad;
    logic [2:0] ec;
    nb = (n + 8) / 64 + 1;
    c0 = cmd_log.size(); v0 = viol; d0 = n_dv;
    exp_q.push_back(use_c ? cexp : sha1_golden(n));
    send_msg(n, gap);
    wait_digest(nm);
    repeat (3) @(negedge clk);
    nc  = cmd_log.size() - c0;
    chk({nm, "_ncmd"}, 512'(nc), 512'(nb + 1));
    bad = 0;
    for (int i = 0; i < nc && i <= nb; i++) begin
      ec = (i == 0) ? 3'b010 : (i == nb) ? 3'b001 : 3'b110;
      if (cmd_log[c0 + i] !== ec) bad++;
    end
    chk({nm, "_cmd_order"}, 512'(bad), 512'd0);
    chk({nm, "_ready_text_gating"}, 512'(viol - v0), 512'd0);
    chk({nm, "_dv_pulses"}, 512'(n_dv - d0), 512'd1);
  endtask

  initial begin
    int b0, dA, c;
    logic [31:0] w7;

    vecs[0]  = '{kind: 0, n: 3,   use_c: 1, cexp: 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, gap: 0};
    vecs[1]  = '{kind: 1, n: 0,   use_c: 1, cexp: 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709, gap: 0};
    vecs[2]  = '{kind: 2, n: 56,  use_c: 1, cexp: 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, gap: 30};
    vecs[3]  = '{kind: 4, n: 1,   use_c: 0, cexp: '0, gap: 0};
    vecs[4]  = '{kind: 4, n: 4,   use_c: 0, cexp: '0, gap: 50};
    vecs[5]  = '{kind: 4, n: 7,   use_c: 0, cexp: '0, gap: 0};
    vecs[6]  = '{kind: 4, n: 52,  use_c: 0, cexp: '0, gap: 20};
    vecs[7]  = '{kind: 4, n: 55,  use_c: 0, cexp: '0, gap: 0};
    vecs[8]  = '{kind: 4, n: 60,  use_c: 0, cexp: '0, gap: 40};
    vecs[9]  = '{kind: 4, n: 63,  use_c: 0, cexp: '0, gap: 0};
    vecs[10] = '{kind: 4, n: 100, use_c: 0, cexp: '0, gap: 30};
    vecs[11] = '{kind: 4, n: 120, use_c: 0, cexp: '0, gap: 0};
    vecs[12] = '{kind: 4, n: 128, use_c: 0, cexp: '0, gap: 25};
    vecs[13] = '{kind: 0, n: 3,   use_c: 1, cexp: 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, gap: 60};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_digest",   512'(digest_o), 512'd0);
    chk("rst_dv",       512'(digest_valid_o), 512'd0);
    chk("rst_cmd_w",    512'(core_cmd_w_o), 512'd0);
    chk("rst_cmd",      512'(core_cmd_o), 512'd0);
    chk("rst_text",     512'(core_text_o), 512'd0);
    chk("rst_in_ready", 512'(in_ready_o), 512'd1);

    for (int v = 0; v < 14; v++) begin
      fill_msg(vecs[v].kind, vecs[v].n);
      run_msg($sformatf("vec%0d_len%0d", v, vecs[v].n), vecs[v].n, vecs[v].use_c, vecs[v].cexp, vecs[v].gap);
    end

    // 64 zero bytes: full data block, then a pad block led by 0x80 with len 0x200
    fill_msg(3, 64);
    b0 = blk_log.size();
    run_msg("zeros64", 64, 1'b0, '0, 0);
    chk("zeros64_nblk", 512'(blk_log.size() - b0), 512'd2);
    if (blk_log.size() - b0 == 2) begin
      chk("zeros64_blk1", blk_log[b0], 512'd0);
      chk("zeros64_blk2", blk_log[b0+1], {32'h8000_0000, 416'd0, 64'h200});
    end

    // reset while the core is receiving word 7, then a clean "abc"
    dA = n_dv;
    fill_msg(4, 64);
    w7 = {msg_mem[28], msg_mem[29], msg_mem[30], msg_mem[31]};
    send_msg(64, 0);
    c = 0;
    do begin @(negedge clk); c++; end while (!core_cmd_w_o && c < 20);
    chk("abort_cmd_seen", 512'(core_cmd_w_o), 512'd1);
    repeat (8) @(negedge clk);
    chk("abort_text_w7", 512'(core_text_o), 512'(w7));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 512'(in_ready_o), 512'd1);
    chk("abort_text_idle", 512'(core_text_o), 512'd0);
    fill_msg(0, 3);
    run_msg("abc_after_reset", 3, 1'b1, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 0);
    chk("abort_no_spurious_dv", 512'(n_dv - dA), 512'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
